// File: rtl/debug_cmd_dispatch_pkg.sv
// Shared types and defaults for the debug command dispatcher.
package debug_cmd_dispatch_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_ISSUE    = 2'd1;
   localparam state_t ST_WAIT_ACK = 2'd2;

   localparam int DEF_IR_W        = 2;
   localparam int DEF_DR_W        = 38;
   localparam int DEF_ACT_BIT     = 34;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_ACK_TIMEOUT = 255;

   function automatic int num_ch(input int ir_w);
      return 1 << ir_w;
   endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchronizer for a JTAG-domain level, followed by a one-cycle
// rising-edge pulse in the clk domain.
module dbg_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic [STAGES-1:0] sync_p0;
   logic              last_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         last_p1 <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], async_in};
         last_p1 <= sync_p0[STAGES-1];
      end
   end

   assign pulse = sync_p0[STAGES-1] & ~last_p1;

endmodule

// File: rtl/debug_cmd_dispatch.sv
// Dispatches JTAG update-DR commands as per-channel action/no-action pulses.
// Optional ack timeout enabled by defining DEBUG_CMD_DISPATCH_TIMEOUT_EN.
module debug_cmd_dispatch
   import debug_cmd_dispatch_pkg::*;
#(
   parameter int IR_W        = DEF_IR_W,
   parameter int DR_W        = DEF_DR_W,
   parameter int ACT_BIT     = DEF_ACT_BIT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   localparam int NUM_CH     = num_ch(IR_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vs_uir,
   input  logic              vs_udr,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [DR_W-1:0]   sr,
   input  logic [NUM_CH-1:0] act_ack,
   output logic [DR_W-1:0]   jdo,
   output logic [IR_W-1:0]   ir_latched,
   output logic [NUM_CH-1:0] take_action,
   output logic [NUM_CH-1:0] take_no_action,
   output logic              busy,
   output logic [7:0]        overrun_cnt,
   output logic              timeout_flag
);

   state_t            state;
   logic [IR_W-1:0]   ch;
   logic [NUM_CH-1:0] ch_onehot;
   logic              uir_pulse;
   logic              udr_pulse;
   logic              ack_hit;
   logic              timeout_hit;

   dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_uir),
      .pulse    (uir_pulse)
   );

   dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_udr),
      .pulse    (udr_pulse)
   );

   // Channel is taken from ir_latched before any same-cycle IR update
   assign ch_onehot = NUM_CH'(1) << ir_latched;
   assign ack_hit   = act_ack[ch];
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         ch             <= '0;
         jdo            <= '0;
         ir_latched     <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         overrun_cnt    <= '0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         if (uir_pulse)
            ir_latched <= ir_in;
         if (udr_pulse && busy && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
         case (state)
            ST_IDLE: begin
               if (udr_pulse) begin
                  jdo <= sr;
                  ch  <= ir_latched;
                  if (sr[ACT_BIT]) begin
                     take_action <= ch_onehot;
                     state       <= ST_ISSUE;
                  end else begin
                     take_no_action <= ch_onehot;
                  end
               end
            end
            ST_ISSUE:    state <= ack_hit ? ST_IDLE : ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack_hit || timeout_hit) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

`ifdef DEBUG_CMD_DISPATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt;

   // Counts completed WAIT_ACK cycles; the ACK_TIMEOUT-th cycle without ack gives up
   assign timeout_hit = (state == ST_WAIT_ACK) && !ack_hit &&
                        (to_cnt == TO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt       <= '0;
         timeout_flag <= 1'b0;
      end else if (state == ST_WAIT_ACK && !ack_hit) begin
         if (timeout_hit) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b1;
         end else begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end else begin
         to_cnt <= '0;
      end
   end
`else
   assign timeout_hit  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/debug_cmd_dispatch.md
DEBUG_CMD_DISPATCH -- requirements
Module: debug_cmd_dispatch

Interface
REQ-001 SHALL have parameter IR_W, default 2, instruction register width; channel count NUM_CH = 2**IR_W.
REQ-002 SHALL have parameter DR_W, default 38, data register and jdo width.
REQ-003 SHALL have parameter ACT_BIT, default 34, jdo bit selecting action (1) versus no-action (0).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, minimum 2, synchronizer depth.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 255, WAIT_ACK cycle limit.
REQ-006 SHALL have ports as follows; the block has one clock, and reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- vs_uir  in  1  update-IR level from the JTAG domain; asynchronous.
- vs_udr  in  1  update-DR level from the JTAG domain; asynchronous.
- ir_in  in  IR_W  instruction; quasi-static around vs_uir.
- sr  in  DR_W  shift register contents; quasi-static around vs_udr.
- act_ack  in  NUM_CH  per-channel action acknowledge.
- jdo  out  DR_W  latched data register.
- ir_latched  out  IR_W  current instruction.
- take_action  out  NUM_CH  one-cycle action pulse.
- take_no_action  out  NUM_CH  one-cycle no-action pulse.
- busy  out  1  high in ISSUE and WAIT_ACK.
- overrun_cnt  out  8  dropped-command count; saturates.
- timeout_flag  out  1  sticky ack-timeout indicator.

Function
REQ-007 SHALL pass each of vs_uir and vs_udr through SYNC_STAGES flops, then rising-edge detect into one-cycle uir_pulse and udr_pulse.
REQ-008 SHALL load ir_latched from ir_in on uir_pulse.
REQ-009 SHALL run FSM states IDLE, ISSUE, WAIT_ACK.
REQ-010 In IDLE, on udr_pulse, SHALL register jdo from sr and select channel c = ir_latched, using the value before any same-cycle uir_pulse update.
REQ-011 If sr[ACT_BIT] = 1: SHALL pulse take_action[c] for one cycle, enter ISSUE, and pass to WAIT_ACK next cycle.
REQ-012 If sr[ACT_BIT] = 0: SHALL pulse take_no_action[c] for one cycle and remain in IDLE.
REQ-013 Latency: a pulse SHALL appear exactly SYNC_STAGES+1 clk edges after the first edge sampling vs_udr high.
REQ-014 In ISSUE or WAIT_ACK, act_ack[c] = 1 SHALL return the FSM to IDLE next cycle; ack on other channels is ignored.
REQ-015 udr_pulse while busy SHALL drop the command: jdo unchanged, no pulse, overrun_cnt +1 saturating at 255.
REQ-016 At most one take_action/take_no_action bit SHALL be high per cycle.
REQ-017 uir_pulse SHALL be honoured in every state.

Reset
REQ-018 reset SHALL asynchronously clear synchronizers, jdo, ir_latched, take_action, take_no_action, busy, overrun_cnt, timeout_flag; FSM goes to IDLE.
REQ-019 Reset mid-WAIT_ACK SHALL abandon the command; an edge-detect leading to a pulse SHALL be required after release.

Configuration
REQ-020 With DEBUG_CMD_DISPATCH_TIMEOUT_EN defined: a counter SHALL run in WAIT_ACK; on reaching ACK_TIMEOUT cycles without ack, FSM goes to IDLE and timeout_flag sets, cleared only by reset.
REQ-021 Without DEBUG_CMD_DISPATCH_TIMEOUT_EN: WAIT_ACK SHALL wait indefinitely, and timeout_flag is tied 0 with the port retained.

Structure
REQ-022 Package debug_cmd_dispatch_pkg SHALL hold the FSM state typedef, default parameter constants, and the NUM_CH derivation.
REQ-023 Sub-module dbg_sync_edge (synchronizer plus rising-edge detect) SHALL be instantiated twice.

Verification
REQ-024 Default parameters; ir_in=2, vs_uir pulse, then sr bit34=1, vs_udr pulse -> take_action=4'b0100 for one cycle 3 edges after sampling, and jdo=sr.
REQ-025 sr bit34=0 on channel 1 -> take_no_action=4'b0010, busy stays 0.
REQ-026 Three vs_udr pulses while awaiting ack -> overrun_cnt=3, jdo unchanged; act_ack[2] then returns busy to 0.
REQ-027 act_ack[1] while waiting on channel 2 -> still busy; with macro and no ack -> after 255 cycles busy=0, timeout_flag=1.
REQ-028 Assert reset during WAIT_ACK -> all outputs 0 immediately; the next command dispatches normally.
REQ-029 IR_W=3, DR_W=44, SYNC_STAGES=3 -> channel 7 action pulse at 4-edge latency.
